// File: rtl/l1_mac_engine.sv
// rtl/l1_mac_engine.sv - layer-1 MAC engine: 32 parallel neurons, bias row, ReLU/saturate stream out
module l1_mac_engine #(
  parameter int N_PIX = 784,
  parameter int SHIFT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [31:0]   ctr1,
  output logic          re,
  input  logic [1023:0] w1_bus,
  output logic [9:0]    pix_addr,
  input  logic [7:0]    pix_data,
  output logic          h_valid,
  input  logic          h_ready,
  output logic [31:0]   h_data,
  output logic [4:0]    h_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

  localparam logic [31:0] BIAS_ROW = 32'(N_PIX);

  state_t             state_q;
  logic [31:0]        ctr1_q;
  logic               re_q;
  logic [9:0]         pix_addr_q;
  logic               h_valid_q;
  logic [31:0]        h_data_q;
  logic [4:0]         h_idx_q;
  logic               busy_q;
  logic               done_q;
  logic               tag_vld_q;
  logic               tag_bias_q;
  logic               bias_done_q;
  logic signed [51:0] acc_q [32];
  logic signed [51:0] acc_d [32];
  logic [31:0]        ctr1_inc;
  logic               acc_clear;

  function automatic logic signed [51:0] mac_step(input logic signed [51:0] acc,
                                                  input logic [31:0] w,
                                                  input logic [7:0] pix,
                                                  input logic is_bias);
    logic signed [51:0] w_ext;
    logic signed [51:0] p_ext;
    w_ext = {{20{w[31]}}, w};
    p_ext = {44'd0, pix};
    mac_step = is_bias ? acc + w_ext : acc + w_ext * p_ext;
  endfunction

  function automatic logic [31:0] relu_sat(input logic signed [51:0] a);
    logic signed [51:0] v;
    v = a >>> SHIFT;
    if (v[51])
      relu_sat = 32'd0;
    else if (v > 52'sd2147483647)
      relu_sat = 32'h7FFF_FFFF;
    else
      relu_sat = v[31:0];
  endfunction

  assign ctr1_inc  = ctr1_q + 32'd1;
  assign acc_clear = (state_q == S_IDLE) && start;

  // The tag registers line up with the read data, which lags the issued address by one edge.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (acc_clear)
        acc_d[i] = '0;
      else if (tag_vld_q)
        acc_d[i] = mac_step(acc_q[i], w1_bus[i*32 +: 32], pix_data, tag_bias_q);
      else
        acc_d[i] = acc_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ctr1_q      <= '0;
      re_q        <= 1'b0;
      pix_addr_q  <= '0;
      h_valid_q   <= 1'b0;
      h_data_q    <= '0;
      h_idx_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_bias_q  <= 1'b0;
      bias_done_q <= 1'b0;
      acc_q       <= '{default: '0};
    end else begin
      done_q     <= 1'b0;
      tag_vld_q  <= re_q;
      tag_bias_q <= (ctr1_q == BIAS_ROW);
      acc_q      <= acc_d;
      if (tag_vld_q && tag_bias_q)
        bias_done_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FETCH;
            ctr1_q      <= '0;
            pix_addr_q  <= '0;
            re_q        <= 1'b1;
            busy_q      <= 1'b1;
            bias_done_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (ctr1_q == BIAS_ROW) begin
            state_q    <= S_DRAIN;
            ctr1_q     <= '0;
            pix_addr_q <= '0;
            re_q       <= 1'b0;
          end else begin
            ctr1_q     <= ctr1_inc;
            pix_addr_q <= ctr1_inc[9:0];
          end
        end
        S_DRAIN: begin
          // Wait one edge past the bias accumulate so acc_q holds final sums.
          if (bias_done_q) begin
            state_q   <= S_OUT;
            h_valid_q <= 1'b1;
            h_idx_q   <= 5'd0;
            h_data_q  <= relu_sat(acc_q[0]);
          end
        end
        S_OUT: begin
          if (h_ready) begin
            if (h_idx_q == 5'd31) begin
              state_q   <= S_IDLE;
              h_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              h_idx_q  <= h_idx_q + 5'd1;
              h_data_q <= relu_sat(acc_q[h_idx_q + 5'd1]);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctr1     = ctr1_q;
  assign re       = re_q;
  assign pix_addr = pix_addr_q;
  assign h_valid  = h_valid_q;
  assign h_data   = h_data_q;
  assign h_idx    = h_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_l1_mac_engine.sv
// tb/tb_l1_mac_engine.sv - directed bench for l1_mac_engine (SHIFT=0 and SHIFT=8 instances)
module tb_l1_mac_engine;
  localparam int N = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_drv, sel, h_ready;
  logic start0, start8;
  logic [31:0] ctr1_0, ctr1_8, h_data_0, h_data_8;
  logic re_0, re_8, h_valid_0, h_valid_8, busy_0, busy_8, done_0, done_8;
  logic [9:0] pix_addr_0, pix_addr_8;
  logic [4:0] h_idx_0, h_idx_8;
  logic [1023:0] w1_0, w1_8;
  logic [7:0] pix_0, pix_8;

  logic [31:0] w_cfg [32];
  logic [31:0] b_cfg [32];
  logic [7:0]  pix_cfg;
  logic [31:0] exp_h [32];

  int checks = 0;
  int errors = 0;

  assign start0 = start_drv & ~sel;
  assign start8 = start_drv & sel;

  l1_mac_engine #(.N_PIX(N), .SHIFT(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .ctr1(ctr1_0), .re(re_0), .w1_bus(w1_0),
    .pix_addr(pix_addr_0), .pix_data(pix_0), .h_valid(h_valid_0), .h_ready(h_ready),
    .h_data(h_data_0), .h_idx(h_idx_0), .busy(busy_0), .done(done_0));

  l1_mac_engine #(.N_PIX(N), .SHIFT(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .ctr1(ctr1_8), .re(re_8), .w1_bus(w1_8),
    .pix_addr(pix_addr_8), .pix_data(pix_8), .h_valid(h_valid_8), .h_ready(h_ready),
    .h_data(h_data_8), .h_idx(h_idx_8), .busy(busy_8), .done(done_8));

  logic [31:0] m_ctr1, m_h_data;
  logic [9:0]  m_pix_addr;
  logic [4:0]  m_h_idx;
  logic        m_re, m_h_valid, m_busy, m_done;
  assign m_ctr1     = sel ? ctr1_8 : ctr1_0;
  assign m_h_data   = sel ? h_data_8 : h_data_0;
  assign m_pix_addr = sel ? pix_addr_8 : pix_addr_0;
  assign m_h_idx    = sel ? h_idx_8 : h_idx_0;
  assign m_re       = sel ? re_8 : re_0;
  assign m_h_valid  = sel ? h_valid_8 : h_valid_0;
  assign m_busy     = sel ? busy_8 : busy_0;
  assign m_done     = sel ? done_8 : done_0;

  function automatic logic [1023:0] mem_row(input logic [31:0] a);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = (a == N) ? b_cfg[i] : w_cfg[i];
    return r;
  endfunction

  // Synchronous-read memories; bias row returns junk pixel data that must be ignored.
  always @(posedge clk) begin
    w1_0  <= mem_row(ctr1_0);
    w1_8  <= mem_row(ctr1_8);
    pix_0 <= (ctr1_0 == N) ? 8'hAA : pix_cfg;
    pix_8 <= (ctr1_8 == N) ? 8'hAA : pix_cfg;
  end

  task automatic set_cfg(input logic [31:0] w, input logic [7:0] p, input logic [31:0] b_step);
    for (int i = 0; i < 32; i++) begin
      w_cfg[i] = w;
      b_cfg[i] = b_step * i;
    end
    pix_cfg = p;
  endtask

  task automatic run_image(input string name, input bit rand_ready, input int start_at);
    bit prev_valid, rdy;
    logic [31:0] prev_data;
    logic [4:0] prev_idx;
    int hs, done_cnt, done_n, first_v;
    hs = 0; done_cnt = 0; done_n = 0; first_v = 0; prev_valid = 0;
    prev_data = '0; prev_idx = '0;
    @(negedge clk); start_drv = 1'b1; h_ready = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    if (!rand_ready) begin
      checks++;
      if (m_ctr1 !== 32'd0 || m_re !== 1'b1 || m_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_issue0: ctr1=%0d re=%b busy=%b want 0 1 1", name, m_ctr1, m_re, m_busy);
      end
    end
    for (int n = 1; n < N + 600; n++) begin
      @(negedge clk);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      h_ready = rdy;
      start_drv = (n == start_at);
      @(posedge clk); #1;
      if (prev_valid && rdy) begin
        checks++;
        if (prev_idx !== hs[4:0] || prev_data !== exp_h[hs[4:0]]) begin
          errors++;
          $display("FAIL %s_hs%0d: idx=%0d data=%0d want idx=%0d data=%0d",
                   name, hs, prev_idx, prev_data, hs, exp_h[hs[4:0]]);
        end
        hs++;
      end else if (prev_valid) begin
        checks++;
        if (m_h_valid !== 1'b1 || m_h_data !== prev_data || m_h_idx !== prev_idx) begin
          errors++;
          $display("FAIL %s_stall: valid=%b idx=%0d data=%0d want 1 %0d %0d",
                   name, m_h_valid, m_h_idx, m_h_data, prev_idx, prev_data);
        end
      end
      if (!rand_ready && (n == 400 || n == N)) begin
        checks++;
        if (m_ctr1 !== 32'(n) || m_pix_addr !== 10'(n) || m_re !== 1'b1) begin
          errors++;
          $display("FAIL %s_fetch%0d: ctr1=%0d pix_addr=%0d re=%b want %0d %0d 1",
                   name, n, m_ctr1, m_pix_addr, m_re, n, n);
        end
      end
      if (!rand_ready && n == N + 1) begin
        checks++;
        if (m_ctr1 !== 32'd0 || m_re !== 1'b0 || m_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_drain: ctr1=%0d re=%b busy=%b want 0 0 1", name, m_ctr1, m_re, m_busy);
        end
      end
      if (m_h_valid && first_v == 0) first_v = n;
      if (m_done) begin done_cnt++; done_n = n; end
      prev_valid = m_h_valid; prev_data = m_h_data; prev_idx = m_h_idx;
      if (done_n != 0 && n >= done_n + 3) break;
    end
    start_drv = 1'b0;
    checks++;
    if (hs != 32 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_count: handshakes=%0d dones=%0d want 32 1", name, hs, done_cnt);
    end
    checks++;
    if (m_busy !== 1'b0 || m_h_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: busy=%b h_valid=%b want 0 0", name, m_busy, m_h_valid);
    end
    if (!rand_ready) begin
      checks++;
      if (first_v != N + 3 || done_n != N + 35) begin
        errors++;
        $display("FAIL %s_latency: first_valid=%0d done=%0d want %0d %0d", name, first_v, done_n, N + 3, N + 35);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_drv = 1'b1; h_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_ctr1 !== 0 || m_re !== 0 || m_pix_addr !== 0 || m_h_valid !== 0 ||
        m_h_data !== 0 || m_h_idx !== 0 || m_busy !== 0 || m_done !== 0) begin
      errors++;
      $display("FAIL reset_state: ctr1=%0d re=%b pa=%0d hv=%b hd=%0d hi=%0d busy=%b done=%b want all 0",
               m_ctr1, m_re, m_pix_addr, m_h_valid, m_h_data, m_h_idx, m_busy, m_done);
    end
    @(negedge clk); reset = 1'b0; start_drv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_ones;
    sel = 1'b0;
    set_cfg(32'd1, 8'd1, 32'd0);
    for (int i = 0; i < 32; i++) exp_h[i] = 32'd784;
    run_image("all_ones", 1'b0, N + 35);
  endtask

  task automatic test_relu_clamp;
    sel = 1'b0;
    set_cfg(32'hFFFF_FFFF, 8'd200, 32'd0);
    for (int i = 0; i < 32; i++) exp_h[i] = 32'd0;
    run_image("relu_clamp", 1'b0, 0);
  endtask

  task automatic test_bias_shift;
    sel = 1'b1;
    set_cfg(32'd5, 8'd0, 32'd256);
    for (int i = 0; i < 32; i++) exp_h[i] = 32'(i);
    run_image("bias_shift", 1'b0, 0);
    sel = 1'b0;
  endtask

  task automatic test_mixed_weights;
    int v;
    sel = 1'b0;
    pix_cfg = 8'd3;
    for (int i = 0; i < 32; i++) begin
      w_cfg[i] = 32'(i - 16);
      b_cfg[i] = 32'd7;
      v = (i - 16) * 2352 + 7;
      exp_h[i] = (v < 0) ? 32'd0 : 32'(v);
    end
    run_image("mixed", 1'b0, 0);
  endtask

  task automatic test_saturation;
    sel = 1'b0;
    set_cfg(32'h7FFF_FFFF, 8'd255, 32'd0);
    for (int i = 0; i < 32; i++) exp_h[i] = 32'h7FFF_FFFF;
    run_image("saturate", 1'b0, 0);
  endtask

  task automatic test_random_ready;
    sel = 1'b0;
    set_cfg(32'd1, 8'd1, 32'd0);
    for (int i = 0; i < 32; i++) exp_h[i] = 32'd784;
    run_image("rand_ready", 1'b1, 300);
  endtask

  task automatic test_reset_mid;
    int dones;
    sel = 1'b0;
    set_cfg(32'd1, 8'd1, 32'd0);
    @(negedge clk); start_drv = 1'b1; h_ready = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    checks++;
    if (m_ctr1 !== 32'd400) begin
      errors++;
      $display("FAIL midreset_ctr: ctr1=%0d want 400", m_ctr1);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_re !== 1'b0 || m_busy !== 1'b0 || m_ctr1 !== 32'd0 || m_h_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: re=%b busy=%b ctr1=%0d hv=%b want 0 0 0 0", m_re, m_busy, m_ctr1, m_h_valid);
    end
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int n = 0; n < N + 50; n++) begin
      @(posedge clk); #1;
      if (m_done || m_busy || m_h_valid) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_quiet: active_cycles=%0d want 0", dones);
    end
    for (int i = 0; i < 32; i++) exp_h[i] = 32'd784;
    run_image("after_reset", 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; start_drv = 1'b0; sel = 1'b0; h_ready = 1'b0;
    set_cfg(32'd0, 8'd0, 32'd0);
    test_reset;
    test_all_ones;
    test_relu_clamp;
    test_bias_shift;
    test_mixed_weights;
    test_saturation;
    test_random_ready;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
